mem_responder: RTL

Memory-side responder for the CPU data-memory request interface. It accepts 8-byte-aligned read and write requests from the memory stage's access unit, applies a configurable access latency, and completes each request with a one-cycle `sig_memread_ok` / `sig_memwrite_ok` pulse. It serves as the on-chip data RAM model in simulation and synthesis, sitting directly below the memory stage.

---
 rtl/mem_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: on-chip 64-bit data RAM with configurable access latency.
//
// Accepts one read or write request at a time from the memory stage.
// Writes win over reads when both are requested. Each access completes
// with a one-cycle ok pulse. A mandatory GAP cycle follows each response.
//
// Parameters:
//   DEPTH   - number of 64-bit words (power of two); index = addr[log2(DEPTH)+2:3]
//   LATENCY - wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk             - clock, rising edge
//   rst             - asynchronous active-low reset
//   ren / raddr     - read request (level) and byte address
//   rdata           - read data, valid with sig_memread_ok, held until next read
//   sig_memread_ok  - one-cycle read-complete pulse
//   wen / waddr     - write request (level) and byte address
//   wdata / wmask   - write data and per-bit write mask (1 = bit written)
//   sig_memwrite_ok - one-cycle write-complete pulse
//   busy            - high whenever the FSM is not in IDLE
//   err             - (only with MEM_RESP_ERR_EN) pulses with ok on out-of-range access
//
// Optional feature macro: MEM_RESP_ERR_EN adds the err output.
module mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ren,
   input  logic [63:0] raddr,
   output logic [63:0] rdata,
   output logic        sig_memread_ok,
   input  logic        wen,
   input  logic [63:0] waddr,
   input  logic [63:0] wdata,
   input  logic [63:0] wmask,
   output logic        sig_memwrite_ok,
   output logic        busy
`ifdef MEM_RESP_ERR_EN
   ,
   output logic        err
`endif
);

   localparam int         IDXW = $clog2(DEPTH);
   localparam logic [3:0] LAT  = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t            state, state_next;
   logic [3:0]        cnt, cnt_next;
   logic              accept, accept_wr;

   logic              lat_write;
   logic [IDXW-1:0]   lat_idx;
   logic              lat_oor;
   logic [63:0]       lat_wdata;
   logic [63:0]       lat_wmask;

   logic [63:0]       mem [DEPTH];

   logic [IDXW-1:0]   ridx, widx;
   logic              roor, woor;
   logic              unused_ok;

   // Address decode: word index plus out-of-range flag (any bit above the index set).
   assign ridx      = raddr[IDXW+2:3];
   assign widx      = waddr[IDXW+2:3];
   assign roor      = |raddr[63:IDXW+3];
   assign woor      = |waddr[63:IDXW+3];
   assign unused_ok = ^{raddr[2:0], waddr[2:0]};

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state, counter and acceptance decode.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      accept_wr  = 1'b0;
      case (state)
         IDLE: begin
            if (wen) begin
               accept    = 1'b1;
               accept_wr = 1'b1;
            end else if (ren) begin
               accept    = 1'b1;
            end else begin
               accept    = 1'b0;
            end
            if (accept) begin
               if (LAT == 4'd0) begin
                  state_next = RESP;
                  cnt_next   = 4'd0;
               end else begin
                  state_next = WAIT;
                  cnt_next   = LAT;
               end
            end else begin
               state_next = IDLE;
            end
         end
         // WAIT lasts exactly LATENCY cycles: leave once the counter shows 1.
         WAIT: begin
            if (cnt <= 4'd1) begin
               state_next = RESP;
               cnt_next   = 4'd0;
            end else begin
               state_next = WAIT;
               cnt_next   = cnt - 4'd1;
            end
         end
         RESP:    state_next = GAP;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latch, response pulses, read data and busy flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt             <= 4'd0;
         busy            <= 1'b0;
         rdata           <= 64'd0;
         sig_memread_ok  <= 1'b0;
         sig_memwrite_ok <= 1'b0;
         lat_write       <= 1'b0;
         lat_idx         <= '0;
         lat_oor         <= 1'b0;
         lat_wdata       <= 64'd0;
         lat_wmask       <= 64'd0;
      end else begin
         cnt             <= cnt_next;
         busy            <= (state_next != IDLE);
         sig_memread_ok  <= 1'b0;
         sig_memwrite_ok <= 1'b0;
         if (accept) begin
            lat_write <= accept_wr;
            lat_idx   <= accept_wr ? widx : ridx;
            lat_oor   <= accept_wr ? woor : roor;
            lat_wdata <= wdata;
            lat_wmask <= wmask;
         end
         if (state == RESP) begin
            if (lat_write) begin
               sig_memwrite_ok <= 1'b1;
            end else begin
               sig_memread_ok  <= 1'b1;
               rdata           <= lat_oor ? 64'd0 : mem[lat_idx];
            end
         end
      end
   end

   // RAM array: masked write at the RESP edge; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (state == RESP && lat_write && !lat_oor) begin
         mem[lat_idx] <= (mem[lat_idx] & ~lat_wmask) | (lat_wdata & lat_wmask);
      end
   end

`ifdef MEM_RESP_ERR_EN
   // Out-of-range status, pulsed alongside the ok pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else begin
         err <= (state == RESP) && lat_oor;
      end
   end
`else
   // Without the err port, out-of-range accesses complete silently.
`endif

endmodule
